// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bundles the read, write and scoreboard signals of the multi-port register
// file into one interface.
//   master : issue/datapath side. Drives read addresses, both write ports and
//            the claim port. Receives read data, per-port busy and the full
//            busy vector.
//   slave  : the register file itself.
// Read ports are packed: port i occupies [i*ADDR_LEN +: ADDR_LEN] of rd_addr
// and [i*DTYPE +: DTYPE] of rd_data.
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
  parameter int DTYPE = 16,
  parameter int NREGS = 8,
  parameter int NREAD = 2
);
  localparam int ADDR_LEN = $clog2(NREGS);

  logic [NREAD*ADDR_LEN-1:0] rd_addr;
  logic [NREAD*DTYPE-1:0]    rd_data;
  logic [NREAD-1:0]          rd_busy;

  logic                      wa_en;
  logic [ADDR_LEN-1:0]       wa_addr;
  logic [DTYPE-1:0]          wa_data;

  logic                      wb_en;
  logic [ADDR_LEN-1:0]       wb_addr;
  logic [DTYPE-1:0]          wb_data;

  logic                      claim_en;
  logic [ADDR_LEN-1:0]       claim_addr;

  logic [NREGS-1:0]          busy;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           claim_en, claim_addr,
    input  rd_data, rd_busy, busy
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           claim_en, claim_addr,
    output rd_data, rd_busy, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port register file with two prioritised write ports (B beats A on an
// address collision), NREAD combinational read ports, optional same-cycle
// write-to-read forwarding and a per-register busy scoreboard for RAW hazard
// detection. Register 0 reads as zero, is never busy, and ignores writes and
// claims.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset; clears storage and scoreboard
//   clk_en : global enable; low freezes storage and scoreboard, no forwarding
//   rf     : regfile_mp_if.slave bundle (reads, write ports A/B, claim, busy)
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DTYPE  = 16,
  parameter int NREGS  = 8,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clk_en,
  regfile_mp_if.slave  rf
);
  localparam int ADDR_LEN = $clog2(NREGS);
  localparam logic [ADDR_LEN:0] NREGS_W = NREGS[ADDR_LEN:0];

  // An address is usable when it is nonzero and names an existing register;
  // the range test only matters when NREGS is not a power of two.
  function automatic logic addr_ok(input logic [ADDR_LEN-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  logic [DTYPE-1:0] regs_q [NREGS];
  logic [DTYPE-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wa_ok, wb_ok, claim_ok, fwd;

  assign wa_ok    = clk_en && rf.wa_en    && addr_ok(rf.wa_addr);
  assign wb_ok    = clk_en && rf.wb_en    && addr_ok(rf.wb_addr);
  assign claim_ok = clk_en && rf.claim_en && addr_ok(rf.claim_addr);
  assign fwd      = (BYPASS != 0) && clk_en;

  // Next-state for storage and scoreboard.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    regs_d = regs_q;
    busy_d = busy_q;
    // Port B is applied after port A so it wins on a shared address.
    if (wa_ok) regs_d[rf.wa_addr] = rf.wa_data;
    if (wb_ok) regs_d[rf.wb_addr] = rf.wb_data;
    // A write retires its producer; a claim in the same cycle is a newer
    // producer, so it is applied last and keeps the register busy.
    if (wa_ok)    busy_d[rf.wa_addr]    = 1'b0;
    if (wb_ok)    busy_d[rf.wb_addr]    = 1'b0;
    if (claim_ok) busy_d[rf.claim_addr] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // NOTE: the storage array is reset here because reset must clear every
  // register immediately; that makes it a flop array rather than a RAM macro.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge regardless of statement order.
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign rf.busy = busy_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_LEN-1:0] a;
    logic [DTYPE-1:0]    data;
    logic                bsy;

    assign a = rf.rd_addr[i*ADDR_LEN +: ADDR_LEN];

    always_comb begin
      data = '0;
      bsy  = 1'b0;
      // Outputs are forced to zero while reset is held, even if a write is
      // presented and forwarding would otherwise expose it.
      if (reset && addr_ok(a)) begin
        data = regs_q[a];
        bsy  = busy_q[a];
        // Forwarded data is the value being produced, so it is not busy.
        if (fwd && wa_ok && (rf.wa_addr == a)) begin
          data = rf.wa_data;
          bsy  = 1'b0;
        end
        if (fwd && wb_ok && (rf.wb_addr == a)) begin
          data = rf.wb_data;
          bsy  = 1'b0;
        end
      end
    end

    assign rf.rd_data[i*DTYPE +: DTYPE] = data;
    assign rf.rd_busy[i]                = bsy;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Drives one stimulus stream into two register files, one with forwarding and
// one without, and compares both against an array-based reference model.
// A directed table covers the main scenarios, hand sequences cover reset
// behaviour, and a randomized phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_regfile_mp;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int NP = 2;
  localparam int AL = 3;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b0;

  logic [NP*AL-1:0] rd_addr = '0;
  logic             wa_en = 1'b0, wb_en = 1'b0, claim_en = 1'b0;
  logic [AL-1:0]    wa_addr = '0, wb_addr = '0, claim_addr = '0;
  logic [DW-1:0]    wa_data = '0, wb_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  regfile_mp_if #(.DTYPE(DW), .NREGS(NR), .NREAD(NP)) if_byp ();
  regfile_mp_if #(.DTYPE(DW), .NREGS(NR), .NREAD(NP)) if_nob ();

  assign if_byp.rd_addr = rd_addr;     assign if_nob.rd_addr = rd_addr;
  assign if_byp.wa_en = wa_en;         assign if_nob.wa_en = wa_en;
  assign if_byp.wa_addr = wa_addr;     assign if_nob.wa_addr = wa_addr;
  assign if_byp.wa_data = wa_data;     assign if_nob.wa_data = wa_data;
  assign if_byp.wb_en = wb_en;         assign if_nob.wb_en = wb_en;
  assign if_byp.wb_addr = wb_addr;     assign if_nob.wb_addr = wb_addr;
  assign if_byp.wb_data = wb_data;     assign if_nob.wb_data = wb_data;
  assign if_byp.claim_en = claim_en;   assign if_nob.claim_en = claim_en;
  assign if_byp.claim_addr = claim_addr; assign if_nob.claim_addr = claim_addr;

  regfile_mp #(.DTYPE(DW), .NREGS(NR), .NREAD(NP), .BYPASS(1)) u_byp (
    .clock(clk), .reset(rst_n), .clk_en(clk_en), .rf(if_byp)
  );
  regfile_mp #(.DTYPE(DW), .NREGS(NR), .NREAD(NP), .BYPASS(0)) u_nob (
    .clock(clk), .reset(rst_n), .clk_en(clk_en), .rf(if_nob)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned m_reg  [NR];
  bit          m_busy [NR];

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) begin
      m_reg[r]  = 0;
      m_busy[r] = 1'b0;
    end
  endfunction

  function automatic int unsigned exp_data(int a, bit byp);
    int unsigned v;
    if (rst_n !== 1'b1 || a == 0) return 0;
    v = m_reg[a];
    if (byp && clk_en) begin
      if (wa_en && int'(wa_addr) == a) v = wa_data;
      if (wb_en && int'(wb_addr) == a) v = wb_data;
    end
    return v;
  endfunction

  function automatic bit exp_rbusy(int a, bit byp);
    if (rst_n !== 1'b1 || a == 0) return 1'b0;
    if (byp && clk_en && ((wa_en && int'(wa_addr) == a) || (wb_en && int'(wb_addr) == a)))
      return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [NR-1:0] exp_vec();
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // What the spec says happens at a rising edge.
  function automatic void model_edge();
    if (rst_n !== 1'b1 || !clk_en) return;
    if (wa_en && wa_addr != 0) m_reg[wa_addr] = wa_data;
    if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
    if (wa_en) m_busy[wa_addr] = 1'b0;
    if (wb_en) m_busy[wb_addr] = 1'b0;
    if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
    m_busy[0] = 1'b0;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NP; i++) begin
      int a;
      a = int'(rd_addr[i*AL +: AL]);
      check($sformatf("%s byp rd_data%0d a=%0d", tag, i, a),
            32'(if_byp.rd_data[i*DW +: DW]), exp_data(a, 1'b1));
      check($sformatf("%s byp rd_busy%0d a=%0d", tag, i, a),
            32'(if_byp.rd_busy[i]), 32'(exp_rbusy(a, 1'b1)));
      check($sformatf("%s nob rd_data%0d a=%0d", tag, i, a),
            32'(if_nob.rd_data[i*DW +: DW]), exp_data(a, 1'b0));
      check($sformatf("%s nob rd_busy%0d a=%0d", tag, i, a),
            32'(if_nob.rd_busy[i]), 32'(exp_rbusy(a, 1'b0)));
    end
    check($sformatf("%s byp busy", tag), 32'(if_byp.busy), 32'(exp_vec()));
    check($sformatf("%s nob busy", tag), 32'(if_nob.busy), 32'(exp_vec()));
  endtask

  // Inputs are set on the falling edge; check, then step one rising edge.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    clk_en = 1'b1; wa_en = 1'b0; wb_en = 1'b0; claim_en = 1'b0;
    wa_addr = '0; wb_addr = '0; claim_addr = '0; wa_data = '0; wb_data = '0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          ce;
    logic          wa_en;  logic [AL-1:0] wa_addr; logic [DW-1:0] wa_data;
    logic          wb_en;  logic [AL-1:0] wb_addr; logic [DW-1:0] wb_data;
    logic          cl_en;  logic [AL-1:0] cl_addr;
    logic [AL-1:0] ra0;
    logic [DW-1:0] e_byp;    // port 0 data, forwarding DUT
    logic [DW-1:0] e_nob;    // port 0 data, non-forwarding DUT
    logic          e_rbusy;  // port 0 rd_busy, forwarding DUT
    logic [NR-1:0] e_busy;   // scoreboard before the edge
  } vec_t;

  vec_t vecs [15];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //            ce wa r  data      wb r  data      cl r  ra  e_byp    e_nob    rb busy
    vecs[0]  = '{1, 1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 3, 16'h1234, 16'h0000, 0, 8'h00};
    vecs[1]  = '{1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 16'h1234, 16'h1234, 0, 8'h00};
    vecs[2]  = '{1, 1, 5, 16'hAAAA, 1, 5, 16'h5555, 0, 0, 5, 16'h5555, 16'h0000, 0, 8'h00};
    vecs[3]  = '{1, 1, 0, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 5, 16'h5555, 16'h5555, 0, 8'h00};
    vecs[4]  = '{1, 0, 0, 16'h0000, 1, 0, 16'hFFFF, 1, 0, 0, 16'h0000, 16'h0000, 0, 8'h00};
    vecs[5]  = '{1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 2, 16'h0000, 16'h0000, 0, 8'h00};
    vecs[6]  = '{1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 16'h0000, 16'h0000, 1, 8'h04};
    vecs[7]  = '{1, 0, 0, 16'h0000, 1, 2, 16'h0042, 0, 0, 2, 16'h0042, 16'h0000, 0, 8'h04};
    vecs[8]  = '{1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 16'h0042, 16'h0042, 0, 8'h00};
    vecs[9]  = '{1, 1, 4, 16'h0007, 0, 0, 16'h0000, 1, 4, 4, 16'h0007, 16'h0000, 0, 8'h00};
    vecs[10] = '{1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 4, 16'h0007, 16'h0007, 1, 8'h10};
    vecs[11] = '{0, 1, 6, 16'hBEEF, 0, 0, 16'h0000, 1, 6, 6, 16'h0000, 16'h0000, 0, 8'h10};
    vecs[12] = '{0, 1, 6, 16'hBEEF, 0, 0, 16'h0000, 1, 6, 6, 16'h0000, 16'h0000, 0, 8'h10};
    vecs[13] = '{1, 1, 6, 16'hBEEF, 0, 0, 16'h0000, 1, 6, 6, 16'hBEEF, 16'h0000, 0, 8'h10};
    vecs[14] = '{1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 6, 16'hBEEF, 16'hBEEF, 1, 8'h50};

    model_reset();

    // Reset held, writes and claims presented: everything must read zero
    // and the writes must be discarded.
    @(negedge clk);
    clk_en = 1'b1; wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'hDEAD;
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
    claim_en = 1'b1; claim_addr = 3'd2;
    for (int a = 0; a < NR; a++) begin
      rd_addr = {3'(a), 3'(a)};
      #1;
      check_all($sformatf("in_reset a=%0d", a));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    for (int a = 0; a < NR; a++) begin
      rd_addr = {3'(a), 3'(a)};
      #1;
      check_all($sformatf("after_reset a=%0d", a));
    end

    // Directed table.
    for (int k = 0; k < 15; k++) begin
      clk_en = vecs[k].ce;
      wa_en = vecs[k].wa_en; wa_addr = vecs[k].wa_addr; wa_data = vecs[k].wa_data;
      wb_en = vecs[k].wb_en; wb_addr = vecs[k].wb_addr; wb_data = vecs[k].wb_data;
      claim_en = vecs[k].cl_en; claim_addr = vecs[k].cl_addr;
      rd_addr = {3'd7 - vecs[k].ra0, vecs[k].ra0};
      #1;
      check($sformatf("vec%0d byp rd_data0", k), 32'(if_byp.rd_data[DW-1:0]), 32'(vecs[k].e_byp));
      check($sformatf("vec%0d nob rd_data0", k), 32'(if_nob.rd_data[DW-1:0]), 32'(vecs[k].e_nob));
      check($sformatf("vec%0d byp rd_busy0", k), 32'(if_byp.rd_busy[0]), 32'(vecs[k].e_rbusy));
      check($sformatf("vec%0d byp busy", k), 32'(if_byp.busy), 32'(vecs[k].e_busy));
      check_all($sformatf("vec%0d", k));
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a write burst.
    idle();
    wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'h9999;
    claim_en = 1'b1; claim_addr = 3'd1;
    rd_addr = {3'd5, 3'd3};
    #1;
    check_all("pre_midreset");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset byp r3", 32'(if_byp.rd_data[DW-1:0]), 32'h0);
    check("midreset nob r5", 32'(if_nob.rd_data[2*DW-1:DW]), 32'h0);
    check("midreset byp busy", 32'(if_byp.busy), 32'h0);
    check_all("midreset");
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    for (int a = 0; a < NR; a++) begin
      rd_addr = {3'(a), 3'(a)};
      #1;
      check_all($sformatf("post_midreset a=%0d", a));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      clk_en     = ($urandom_range(0, 7) != 0);
      wa_en      = 1'($urandom_range(0, 1));
      wa_addr    = 3'($urandom_range(0, NR - 1));
      wa_data    = 16'($urandom);
      wb_en      = 1'($urandom_range(0, 1));
      wb_addr    = ($urandom_range(0, 3) == 0) ? wa_addr : 3'($urandom_range(0, NR - 1));
      wb_data    = 16'($urandom);
      claim_en   = ($urandom_range(0, 2) == 0);
      claim_addr = ($urandom_range(0, 3) == 0) ? wa_addr : 3'($urandom_range(0, NR - 1));
      rd_addr    = ($urandom_range(0, 2) == 0) ? {wb_addr, wa_addr} : 6'($urandom);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write register file used by the datapath.
- N combinational read ports, two write ports (A: ALU writeback, B: load/late writeback) with fixed priority, and optional write-to-read bypass.
- Per-register busy scoreboard, so issue logic can detect RAW hazards without an external table.
- Register 0 is hardwired to zero.

Parameters:
DTYPE, 16, data width in bits
NREGS, 8, number of architectural registers (>=2)
NREAD, 2, number of read ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
ADDR_LEN, $clog2(NREGS), register address width (derived)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
clk_en  input  1  global enable; low freezes all state
rd_addr  input  NREAD*ADDR_LEN  packed read addresses; port i at bits [i*ADDR_LEN +: ADDR_LEN]
rd_data  output  NREAD*DTYPE  packed read data, same packing
rd_busy  output  NREAD  port i source register has an outstanding producer
wa_en  input  1  write port A enable
wa_addr  input  ADDR_LEN  write port A address
wa_data  input  DTYPE  write port A data
wb_en  input  1  write port B enable
wb_addr  input  ADDR_LEN  write port B address
wb_data  input  DTYPE  write port B data
claim_en  input  1  mark a destination register busy (issue of a producer)
claim_addr  input  ADDR_LEN  register to mark busy
busy  output  NREGS  full scoreboard vector; bit 0 always 0

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers clear to 0 and all busy bits clear immediately, without waiting for a clock edge.
  - rd_data is 0 and rd_busy is 0 while reset is held.
  - A reset mid-write discards the write.
- Register 0:
  - Reads always return 0; rd_busy is 0 for address 0.
  - Writes to address 0 are discarded; claims of address 0 are ignored.
- Writes:
  - Committed at the rising edge when clk_en=1 and the port enable is 1.
  - One-cycle write latency into storage.
  - Both ports to the same nonzero address in one cycle: port B wins, port A is dropped.
- Reads: combinational from rd_addr.
  - BYPASS=1, clk_en=1, and an enabled write targets rd_addr (nonzero): rd_data returns the write data, using port B data if both ports match. Zero-latency forwarding.
  - BYPASS=0: rd_data shows the new value the cycle after the edge.
  - clk_en=0: no forwarding; stored value only.
- Scoreboard, updated at the rising edge when clk_en=1:
  - claim_en=1 sets busy[claim_addr].
  - An enabled write on either port clears busy[addr].
  - Claim and write to the same address in one cycle: claim wins, busy stays 1 (a new producer supersedes the old one; the write data is still stored).
  - Claiming an already-busy register keeps it busy.
  - A write to a non-busy register is legal; busy stays 0.
- rd_busy[i] = busy[rd_addr_i], except:
  - BYPASS=1, clk_en=1, and an enabled write to that address this cycle: rd_busy[i]=0 (the value is being forwarded).
  - Address 0: rd_busy[i]=0.
- clk_en=0: storage and busy hold regardless of enables.
- No out-of-range addresses exist when NREGS is a power of 2. Otherwise, writes and claims to addresses >= NREGS are discarded and reads of them return 0.

Test Plan:
- Reset then read all ports at addresses 0..7 -> rd_data=0, rd_busy=0, busy=0. Assert reset mid-burst with registers nonzero -> outputs read 0 before the next edge.
- wa_en=1, wa_addr=3, wa_data=0x1234 while port 0 reads 3:
  - BYPASS=1 -> rd_data0=0x1234 in the same cycle.
  - BYPASS=0 -> 0x0000 this cycle, 0x1234 the next.
- Same cycle: wa to r5=0xAAAA and wb to r5=0x5555 -> r5 reads 0x5555. Write 0xFFFF to r0 -> r0 reads 0, busy[0]=0.
- claim r2, then r2 busy -> rd_busy=1 while read. Write r2 via wb=0x0042 -> busy[2] clears after the edge; with BYPASS=1, rd_busy=0 and rd_data=0x0042 in the write cycle.
- Same cycle: claim r4 and wa write r4=0x0007 -> busy[4]=1 and r4=0x0007.
- clk_en=0 with writes and claims asserted to r6 -> r6 and busy unchanged. Raise clk_en -> the writes take effect.
